alu_decode_ctrl: RTL
====================

ALU_DECODE_CTRL -- requirements
Module: alu_decode_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr_d  input  32  RV32I instruction word in the decode stage.
REQ-005 valid_d  input  1  instr_d holds a real instruction this cycle.
REQ-006 stall  input  1  hold the execute-stage register contents.
REQ-007 flush  input  1  replace the execute-stage register contents with a bubble.
REQ-008 alu_op_e  output  5  ALU operation code for the execute stage.
REQ-009 sel_a_e  output  1  ALU SrcA select: 0 = rs1, 1 = PC.
REQ-010 sel_b_e  output  1  ALU SrcB select: 0 = rs2, 1 = immediate.
REQ-011 reg_wr_e, mem_rd_e, mem_wr_e, br_e, jump_e  output  1 each  execute-stage control strobes.
REQ-012 wb_sel_e  output  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-013 valid_e, illegal_e  output  1 each  stage valid flag and illegal-instruction flag.

Function
REQ-014 SHALL decode instr_d combinationally and register all outputs, giving 1-cycle latency from decode to execute.
REQ-015 SHALL use this alu_op encoding: ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001, PASSB 01010.
REQ-016 Opcode 0110011 (R-type) SHALL decode funct3/funct7[5] to the matching op, with sel_a=0, sel_b=0, reg_wr=1, wb=00.
REQ-017 Opcode 0010011 (I-ALU) SHALL be as R-type but with sel_b=1; funct3=000 SHALL always be ADD; funct3=101 SHALL select SRA when funct7[5]=1, otherwise SRL.
REQ-018 Load 0000011 SHALL decode to ADD, sel_b=1, mem_rd=1, reg_wr=1, wb=01.
REQ-019 Store 0100011 SHALL decode to ADD, sel_b=1, mem_wr=1, reg_wr=0.
REQ-020 Branch 1100011 SHALL decode to SUB, sel_b=0, br=1, reg_wr=0.
REQ-021 LUI 0110111 SHALL decode to PASSB, sel_b=1, reg_wr=1.
REQ-022 AUIPC 0010111 SHALL decode to ADD, sel_a=1, sel_b=1, reg_wr=1.
REQ-023 JAL 1101111 SHALL decode to ADD, sel_a=1, sel_b=1, jump=1, reg_wr=1, wb=10.
REQ-024 JALR 1100111 SHALL decode to ADD, sel_a=0, sel_b=1, jump=1, reg_wr=1, wb=10.
REQ-025 Any other opcode, or an R-type funct7 other than 0000000/0100000 (0100000 permitted only with funct3 000 or 101), SHALL register valid_e=1, illegal_e=1, all strobes 0, alu_op=ADD.
REQ-026 Bubble state SHALL be: valid_e=0, illegal_e=0, all strobes 0, sel_a=sel_b=0, wb=00, alu_op=00000.
REQ-027 When valid_d=0 and there is no stall, SHALL load a bubble.
REQ-028 When stall=1 and flush=0, SHALL hold every output unchanged.
REQ-029 flush=1 SHALL load a bubble on the next edge regardless of stall or valid_d; flush SHALL take priority over stall.
REQ-030 Strobes reg_wr/mem_rd/mem_wr/br/jump SHALL never be 1 while valid_e=0.

Reset
REQ-031 While rst_n=0, SHALL asynchronously force the bubble state on all outputs.
REQ-032 The first rising edge after rst_n deasserts SHALL register normally per REQ-027..029.

Verification
REQ-033 instr_d=0x40B50533 (sub x10,x10,x11), valid_d=1 -> next cycle alu_op_e=00001, sel_b_e=0, reg_wr_e=1, valid_e=1.
REQ-034 instr_d=0x4055D513 (srai x10,x11,5) -> alu_op_e=00111, sel_b_e=1; instr_d=0x0055D513 (srli) -> alu_op_e=00110.
REQ-035 instr_d=0x123452B7 (lui) -> alu_op_e=01010, sel_b_e=1; instr_d=0x008000EF (jal) -> jump_e=1, sel_a_e=1, wb_sel_e=10.
REQ-036 Load an add, then assert stall for 3 cycles with instr_d changing -> outputs are frozen; assert stall=1 and flush=1 together -> bubble next cycle.
REQ-037 instr_d=0xFFFFFFFF, valid_d=1 -> valid_e=1, illegal_e=1, all strobes 0.
REQ-038 Drop rst_n asynchronously mid-stream between clock edges -> outputs reach the bubble state immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_decode_ctrl.sv
// RV32I decode-to-execute control register: decodes instr_d combinationally and registers ALU/memory/writeback controls.
// Latency 1 cycle; stall holds the execute register, flush (priority over stall) and valid_d=0 load a bubble.
module alu_decode_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall,
  input  logic        flush,
  output logic [4:0]  alu_op_e,
  output logic        sel_a_e,
  output logic        sel_b_e,
  output logic        reg_wr_e,
  output logic        mem_rd_e,
  output logic        mem_wr_e,
  output logic        br_e,
  output logic        jump_e,
  output logic [1:0]  wb_sel_e,
  output logic        valid_e,
  output logic        illegal_e
);

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic [4:0] alu_op;
    logic       sel_a;
    logic       sel_b;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       br;
    logic       jump;
    logic [1:0] wb_sel;
  } ctrl_t;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00010;
  localparam logic [4:0] OP_SLT   = 5'b00011;
  localparam logic [4:0] OP_SLTU  = 5'b00100;
  localparam logic [4:0] OP_XOR   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_PASSB = 5'b01010;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_legal;
  logic       unused_fields;
  ctrl_t      dec;
  ctrl_t      ex_q;

  assign opcode        = instr_d[6:0];
  assign funct3        = instr_d[14:12];
  assign funct7        = instr_d[31:25];
  assign unused_fields = ^{instr_d[24:15], instr_d[11:7]};

  // The alternate funct7 encoding only exists for SUB and SRA.
  assign r_legal = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  function automatic logic [4:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (opcode)
      OPC_R: begin
        if (r_legal) begin
          dec.alu_op = f3_op(funct3, funct7[5]);
          dec.reg_wr = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_I: begin
        // Bit 30 is immediate data for ADDI, so only SRAI honours it.
        dec.alu_op = f3_op(funct3, funct7[5] && (funct3 == 3'b101));
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
      end
      OPC_LOAD: begin
        dec.sel_b  = 1'b1;
        dec.mem_rd = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b01;
      end
      OPC_STORE: begin
        dec.sel_b  = 1'b1;
        dec.mem_wr = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op = OP_SUB;
        dec.br     = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op = OP_PASSB;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.jump   = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b10;
      end
      OPC_JALR: begin
        dec.sel_b  = 1'b1;
        dec.jump   = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = 2'b10;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (!stall) begin
      ex_q <= valid_d ? dec : '0;
    end
  end

  assign valid_e   = ex_q.valid;
  assign illegal_e = ex_q.illegal;
  assign alu_op_e  = ex_q.alu_op;
  assign sel_a_e   = ex_q.sel_a;
  assign sel_b_e   = ex_q.sel_b;
  assign reg_wr_e  = ex_q.reg_wr;
  assign mem_rd_e  = ex_q.mem_rd;
  assign mem_wr_e  = ex_q.mem_wr;
  assign br_e      = ex_q.br;
  assign jump_e    = ex_q.jump;
  assign wb_sel_e  = ex_q.wb_sel;

endmodule
